// File: rtl/mac_layer1_scheduler_pkg.sv
// Shared constants and FSM encoding for the layer-1 MAC scheduler.
package mac_layer1_scheduler_pkg;

  localparam int L1_S           = 25;
  localparam int L1_WIDTH       = 8;
  localparam int L1_NUM_NEURONS = 6;
  localparam int L1_ADDR_W      = 3;
  localparam int L1_MEM_W       = 12;

  localparam logic signed [L1_MEM_W-1:0] L1_THRESH  = 12'sd100;
  localparam logic signed [L1_MEM_W-1:0] L1_SAT_MAX = {1'b0, {(L1_MEM_W-1){1'b1}}};
  localparam logic signed [L1_MEM_W-1:0] L1_SAT_MIN = {1'b1, {(L1_MEM_W-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mac_layer1_scheduler_membrane_update.sv
// Integrates one datapath result into a membrane potential: saturating add,
// threshold compare, and reset-to-zero on fire.
module mac_layer1_scheduler_membrane_update
  import mac_layer1_scheduler_pkg::*;
#(
  parameter int                       WIDTH   = L1_WIDTH,
  parameter int                       MEM_W   = L1_MEM_W,
  parameter logic signed [MEM_W-1:0]  THRESH  = L1_THRESH,
  parameter logic signed [MEM_W-1:0]  SAT_MAX = L1_SAT_MAX,
  parameter logic signed [MEM_W-1:0]  SAT_MIN = L1_SAT_MIN
) (
  input  logic signed [MEM_W-1:0] pot_i,
  input  logic signed [WIDTH-1:0] mac_out_i,
  output logic signed [MEM_W-1:0] next_pot_o,
  output logic                    fire_o
);

  logic signed [MEM_W:0]   sum_s;
  logic signed [MEM_W-1:0] sat_s;

  // One guard bit catches overflow; top two bits disagreeing means clamp.
  always_comb begin
    sum_s = {pot_i[MEM_W-1], pot_i} + {{(MEM_W+1-WIDTH){mac_out_i[WIDTH-1]}}, mac_out_i};
    if (sum_s[MEM_W] != sum_s[MEM_W-1]) begin
      if (sum_s[MEM_W]) begin
        sat_s = SAT_MIN;
      end else begin
        sat_s = SAT_MAX;
      end
    end else begin
      sat_s = sum_s[MEM_W-1:0];
    end
    fire_o = (sat_s >= THRESH);
    if (fire_o) begin
      next_pot_o = {MEM_W{1'b0}};
    end else begin
      next_pot_o = sat_s;
    end
  end

endmodule

// File: rtl/mac_layer1_scheduler.sv
// Shares one layer-1 MAC+bias datapath across NUM_NEURONS neurons: per frame it
// fetches each neuron's weights, evaluates, integrates, and publishes a spike vector.
module mac_layer1_scheduler
  import mac_layer1_scheduler_pkg::*;
#(
  parameter int                      S           = L1_S,
  parameter int                      WIDTH       = L1_WIDTH,
  parameter int                      NUM_NEURONS = L1_NUM_NEURONS,
  parameter int                      ADDR_W      = L1_ADDR_W,
  parameter int                      MEM_W       = L1_MEM_W,
  parameter logic signed [MEM_W-1:0] THRESH      = L1_THRESH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   clear_mem_i,
  input  logic [S-1:0]           pixels_in_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [NUM_NEURONS-1:0] spikes_o,
  output logic                   w_rd_en_o,
  output logic [ADDR_W-1:0]      w_addr_o,
  input  logic [S*WIDTH-1:0]     w_rdata_i,
  input  logic [WIDTH-1:0]       b_rdata_i,
  output logic [S-1:0]           mac_pixels_o,
  output logic [S*WIDTH-1:0]     mac_weights_o,
  output logic [WIDTH-1:0]       mac_bias_o,
  input  logic [WIDTH-1:0]       mac_out_i
);

  localparam logic [ADDR_W-1:0]       LAST_N  = ADDR_W'(NUM_NEURONS - 1);
  localparam logic signed [MEM_W-1:0] SAT_MAX = {1'b0, {(MEM_W-1){1'b1}}};
  localparam logic signed [MEM_W-1:0] SAT_MIN = {1'b1, {(MEM_W-1){1'b0}}};

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       n_q, n_d;
  logic signed [MEM_W-1:0] pot_q [NUM_NEURONS];
  logic signed [MEM_W-1:0] pot_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]  acc_q, acc_d;
  logic [NUM_NEURONS-1:0]  spikes_q, spikes_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    w_rd_en_q, w_rd_en_d;
  logic [ADDR_W-1:0]       w_addr_q, w_addr_d;
  logic [S-1:0]            pix_q, pix_d;
  logic [S*WIDTH-1:0]      weights_q, weights_d;
  logic [WIDTH-1:0]        bias_q, bias_d;

  logic signed [MEM_W-1:0] pot_sel_s;
  logic signed [MEM_W-1:0] next_pot_s;
  logic                    fire_s;

  assign pot_sel_s = pot_q[n_q];

  mac_layer1_scheduler_membrane_update #(
    .WIDTH   (WIDTH),
    .MEM_W   (MEM_W),
    .THRESH  (THRESH),
    .SAT_MAX (SAT_MAX),
    .SAT_MIN (SAT_MIN)
  ) u_membrane_update (
    .pot_i      (pot_sel_s),
    .mac_out_i  ($signed(mac_out_i)),
    .next_pot_o (next_pot_s),
    .fire_o     (fire_s)
  );

  // Next-state, datapath operand and registered-output decode.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    pot_d     = pot_q;
    acc_d     = acc_q;
    spikes_d  = spikes_q;
    pix_d     = pix_q;
    weights_d = weights_q;
    bias_d    = bias_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_mem_i) begin
          for (int i = 0; i < NUM_NEURONS; i++) begin
            pot_d[i] = {MEM_W{1'b0}};
          end
        end else begin
          pot_d = pot_q;
        end
        if (start_i) begin
          pix_d   = pixels_in_i;
          n_d     = {ADDR_W{1'b0}};
          acc_d   = {NUM_NEURONS{1'b0}};
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        weights_d = w_rdata_i;
        bias_d    = b_rdata_i;
        state_d   = ST_EVAL;
      end
      ST_EVAL: begin
        pot_d[n_q] = next_pot_s;
        acc_d[n_q] = fire_s;
        if (n_q == LAST_N) begin
          spikes_d = acc_d;
          state_d  = ST_DONE;
        end else begin
          n_d     = n_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    w_rd_en_d = (state_d == ST_FETCH);
    if (state_d == ST_FETCH) begin
      w_addr_d = n_d;
    end else begin
      w_addr_d = w_addr_q;
    end
  end

  // State, potentials and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      n_q       <= {ADDR_W{1'b0}};
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot_q[i] <= {MEM_W{1'b0}};
      end
      acc_q     <= {NUM_NEURONS{1'b0}};
      spikes_q  <= {NUM_NEURONS{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_rd_en_q <= 1'b0;
      w_addr_q  <= {ADDR_W{1'b0}};
      pix_q     <= {S{1'b0}};
      weights_q <= {(S*WIDTH){1'b0}};
      bias_q    <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      pot_q     <= pot_d;
      acc_q     <= acc_d;
      spikes_q  <= spikes_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_rd_en_q <= w_rd_en_d;
      w_addr_q  <= w_addr_d;
      pix_q     <= pix_d;
      weights_q <= weights_d;
      bias_q    <= bias_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign spikes_o      = spikes_q;
  assign w_rd_en_o     = w_rd_en_q;
  assign w_addr_o      = w_addr_q;
  assign mac_pixels_o  = pix_q;
  assign mac_weights_o = weights_q;
  assign mac_bias_o    = bias_q;

endmodule

// File: tb/tb_mac_layer1_scheduler.sv
// Directed bench for mac_layer1_scheduler with a weight-memory model and a
// bias-plus-masked-weight-sum datapath model.
module tb_mac_layer1_scheduler;

  localparam int S  = 25;
  localparam int W  = 8;
  localparam int NN = 6;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst, start, clear_mem;
  logic [S-1:0]    pixels_in;
  logic            busy, done, w_rd_en;
  logic [NN-1:0]   spikes;
  logic [AW-1:0]   w_addr;
  logic [S*W-1:0]  w_rdata, mac_weights;
  logic [W-1:0]    b_rdata, mac_bias, mac_out, dp_acc;
  logic [S-1:0]    mac_pixels;

  logic [W-1:0]    bias_mem [8];
  logic [S*W-1:0]  w_mem    [8];

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          clr;
    logic [47:0]   bias;   // {n5,n4,n3,n2,n1,n0}
    logic [NN-1:0] exp_spk;
  } vec_t;

  vec_t tbl [9];

  mac_layer1_scheduler dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .clear_mem_i   (clear_mem),
    .pixels_in_i   (pixels_in),
    .busy_o        (busy),
    .done_o        (done),
    .spikes_o      (spikes),
    .w_rd_en_o     (w_rd_en),
    .w_addr_o      (w_addr),
    .w_rdata_i     (w_rdata),
    .b_rdata_i     (b_rdata),
    .mac_pixels_o  (mac_pixels),
    .mac_weights_o (mac_weights),
    .mac_bias_o    (mac_bias),
    .mac_out_i     (mac_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      w_rdata <= '0;
      b_rdata <= '0;
    end else if (w_rd_en) begin
      w_rdata <= w_mem[w_addr];
      b_rdata <= bias_mem[w_addr];
    end
  end

  always_comb begin
    dp_acc = mac_bias;
    for (int i = 0; i < S; i++)
      if (mac_pixels[i]) dp_acc = dp_acc + mac_weights[i*W +: W];
    mac_out = dp_acc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; clear_mem = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_bias(input logic [47:0] b);
    for (int i = 0; i < NN; i++) bias_mem[i] = b[i*8 +: 8];
  endtask

  // Starts a frame, scrambles pixels_in after acceptance, waits for done.
  task automatic run_frame(input logic [47:0] b, input logic clr, output logic [NN-1:0] spk);
    logic got;
    set_bias(b);
    start = 1'b1; clear_mem = clr;
    tick();
    start = 1'b0; clear_mem = 1'b0;
    pixels_in = ~pixels_in;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done) got = 1'b1;
      else tick();
    end
    check("frame_done_seen", {31'd0, got}, 32'd1);
    spk = spikes;
    tick();
  endtask

  initial begin
    logic [NN-1:0] spk;
    logic          exp_rd, exp_busy, exp_done, found;
    logic [AW-1:0] exp_addr;
    int            ndone;

    pixels_in = '0;
    for (int i = 0; i < 8; i++) begin
      bias_mem[i] = '0;
      w_mem[i]    = '0;
    end
    tbl[0] = {1'b0, 48'h00_00_00_28_00_00, 6'b000000};
    tbl[1] = {1'b0, 48'h00_00_00_28_00_00, 6'b000000};
    tbl[2] = {1'b0, 48'h00_00_00_28_00_00, 6'b000100};
    tbl[3] = {1'b0, 48'h00_00_00_28_00_00, 6'b000000};
    tbl[4] = {1'b0, 48'h64_64_64_64_64_64, 6'b111111};
    tbl[5] = {1'b0, 48'h63_63_63_63_63_63, 6'b000000};
    tbl[6] = {1'b0, 48'h01_01_01_01_01_80, 6'b111110};
    tbl[7] = {1'b1, 48'h00_00_00_00_63_7F, 6'b000001};
    tbl[8] = {1'b0, 48'h00_00_00_00_01_00, 6'b000010};

    // Reset state
    do_reset();
    check("rst_ctrl", {28'd0, busy, done, w_rd_en, 1'b0}, 32'd0);
    check("rst_spikes", {26'd0, spikes}, 32'd0);
    check("rst_addr", {29'd0, w_addr}, 32'd0);
    check("rst_mac", {30'd0, (mac_weights != '0), (mac_bias != '0 || mac_pixels != '0)}, 32'd0);

    // Latency and back-to-back with start held high
    set_bias(48'h0A_0A_0A_0A_0A_0A);
    start = 1'b1;
    tick();
    for (int k = 1; k <= 41; k++) begin
      exp_rd   = (k <= 16 && (k - 1) % 3 == 0) || (k >= 21 && k <= 36 && (k - 21) % 3 == 0);
      exp_addr = !exp_rd ? 3'd0 : (k <= 16 ? 3'((k - 1) / 3) : 3'((k - 21) / 3));
      exp_busy = (k <= 19) || (k >= 21 && k <= 39);
      exp_done = (k == 19) || (k == 39);
      check($sformatf("lat_cycle_%0d", k),
            {26'd0, busy, done, w_rd_en, (exp_rd ? w_addr : 3'd0)},
            {26'd0, exp_busy, exp_done, exp_rd, exp_addr});
      if (k == 21) start = 1'b0;
      tick();
    end
    check("lat_spikes", {26'd0, spikes}, 32'd0);

    // Table-driven integrate / threshold / clear frames
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i].bias, tbl[i].clr, spk);
      check($sformatf("tbl_%0d", i), {26'd0, spk}, {26'd0, tbl[i].exp_spk});
    end

    // Negative saturation then climb back
    do_reset();
    for (int f = 1; f <= 20; f++) begin
      run_frame(48'h00_00_00_00_00_80, 1'b0, spk);
      check($sformatf("negsat_%0d", f), {26'd0, spk}, 32'd0);
    end
    for (int f = 1; f <= 17; f++) begin
      run_frame(48'h00_00_00_00_00_7F, 1'b0, spk);
      check($sformatf("climb_%0d", f), {26'd0, spk}, (f == 17) ? 32'd1 : 32'd0);
    end

    // Pixels latched on start, weights reach the datapath
    do_reset();
    w_mem[4][0 +: 8]   = 8'd60;
    w_mem[4][8 +: 8]   = 8'd50;
    w_mem[4][192 +: 8] = 8'd40;
    pixels_in = 25'h1000001;
    run_frame(48'h0, 1'b0, spk);
    check("pix_spikes", {26'd0, spk}, 32'h10);
    check("pix_latched", {7'd0, mac_pixels}, 32'h1000001);
    w_mem[4] = '0;
    pixels_in = '0;

    // Start and clear_mem while busy are ignored
    do_reset();
    run_frame(48'h00_00_00_00_00_5A, 1'b0, spk);
    check("busy_pre", {26'd0, spk}, 32'd0);
    set_bias(48'h00_00_00_00_00_05);
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      if (k == 5) begin start = 1'b1; clear_mem = 1'b1; end
      if (k == 6) begin start = 1'b0; clear_mem = 1'b0; end
      if (done) ndone++;
      tick();
    end
    check("busy_single_done", ndone, 32'd1);
    check("busy_spk", {26'd0, spikes}, 32'd0);
    run_frame(48'h00_00_00_00_00_05, 1'b0, spk);
    check("busy_clear_ignored", {26'd0, spk}, 32'd1);
    run_frame(48'h00_00_00_00_00_5A, 1'b0, spk);
    check("clr_setup", {26'd0, spk}, 32'd0);
    run_frame(48'h00_00_00_00_00_14, 1'b1, spk);
    check("clr_start", {26'd0, spk}, 32'd0);
    run_frame(48'h00_00_00_00_00_50, 1'b0, spk);
    check("clr_pot20", {26'd0, spk}, 32'd1);

    // Reset during EVAL of neuron 3
    do_reset();
    run_frame(48'h00_00_3C_00_00_00, 1'b0, spk);
    check("mid_setup", {26'd0, spk}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (w_rd_en && w_addr == 3'd3) found = 1'b1;
      else tick();
    end
    check("mid_fetch3_seen", {31'd0, found}, 32'd1);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_after_rst", {26'd0, busy, done, w_rd_en, 3'd0}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      if (done || busy) ndone++;
      tick();
    end
    check("mid_no_done", ndone, 32'd0);
    check("mid_spikes", {26'd0, spikes}, 32'd0);
    run_frame(48'h00_00_3C_00_00_00, 1'b0, spk);
    check("mid_frame1", {26'd0, spk}, 32'd0);
    run_frame(48'h00_00_3C_00_00_00, 1'b0, spk);
    check("mid_frame2", {26'd0, spk}, 32'h08);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_layer1_scheduler.md
Name: mac_layer1_scheduler

Overview:
- Time-multiplexes one layer-1 MAC+bias datapath (25 binary pixels x 25 8-bit weights + 8-bit bias -> 8-bit signed result) across NUM_NEURONS output neurons.
- Per frame: latches the spike/pixel vector, fetches each neuron's weights and bias from the weight memory, drives the datapath, and integrates each result into a per-neuron membrane potential.
- Emits one spike vector per frame; sits between the input spike source and the layer-2 logic.

Parameters:
- S, 25, pixels per receptive field.
- WIDTH, 8, weight and bias width in bits.
- NUM_NEURONS, 6, neurons sharing the datapath.
- ADDR_W, 3, weight-memory address width (must satisfy 2^ADDR_W >= NUM_NEURONS).
- MEM_W, 12, signed membrane potential width.
- THRESH, 100, signed firing threshold (MEM_W bits).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin a frame; sampled only in IDLE.
- clear_mem, input, 1, zero all potentials; sampled only in IDLE.
- pixels_in, input, S, frame spike vector; latched on accepted start.
- busy, output, 1, high from the cycle after an accepted start through the DONE cycle.
- done, output, 1, one-cycle pulse when the spike vector is updated.
- spikes, output, NUM_NEURONS, spike vector of the last completed frame.
- w_rd_en, output, 1, weight-memory read strobe.
- w_addr, output, ADDR_W, neuron index being fetched.
- w_rdata, input, S*WIDTH, weights; valid the cycle after w_rd_en.
- b_rdata, input, WIDTH, bias; same address and latency as w_rdata.
- mac_pixels, output, S, latched frame pixels to the datapath.
- mac_weights, output, S*WIDTH, registered weights to the datapath.
- mac_bias, output, WIDTH, registered bias to the datapath.
- mac_out, input, WIDTH, signed datapath result; combinational from mac_* outputs.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - busy=0, done=0, spikes=0, w_rd_en=0, w_addr=0.
  - mac_pixels/mac_weights/mac_bias=0.
  - All potentials=0, neuron counter n=0.
  - Reset mid-frame aborts the frame, with no done and no spikes update.
- FSM states and transitions:
  - IDLE:
    - If clear_mem=1, zero all potentials.
    - If start=1, latch pixels_in into mac_pixels, set n=0, go to FETCH.
    - If clear_mem and start are both high in the same cycle, the clear applies and the frame starts from zero potentials.
  - FETCH: w_rd_en=1, w_addr=n; go to LOAD.
  - LOAD: register w_rdata into mac_weights and b_rdata into mac_bias; go to EVAL.
  - EVAL:
    - mac_out is valid; perform the membrane update for neuron n.
    - If n==NUM_NEURONS-1, go to DONE; else n=n+1 and go to FETCH.
  - DONE: spikes <= accumulated frame spike bits, done=1 for this cycle only; go to IDLE.
- Control signal rules:
  - w_rd_en is high only in FETCH.
  - start and clear_mem are ignored outside IDLE.
- Latency: accepted start in cycle t gives done in cycle t+3*NUM_NEURONS+1 (t+19 at default).
  - Back-to-back: start held high is re-accepted in the IDLE cycle after DONE.
  - Frame period is therefore 3*NUM_NEURONS+2 cycles.
- Membrane update:
  - sum = pot[n] + sign_extend(mac_out) to MEM_W+1 bits.
  - Saturate sum to [-2^(MEM_W-1), 2^(MEM_W-1)-1].
  - If the saturated value >= THRESH (signed compare): frame spike bit n=1, pot[n] <= 0.
  - Otherwise: bit n=0, pot[n] <= saturated value.
- Spike bits accumulate in an internal vector cleared at frame start; spikes changes only in DONE.

Decomposition:
- Shared package (layer1 pkg):
  - S, WIDTH, MEM_W constants.
  - FSM state enum: IDLE, FETCH, LOAD, EVAL, DONE.
  - Saturation min/max constants.
- Sub-module membrane_update: combinational; inputs pot and mac_out; outputs next_pot and fire; carries the saturate and threshold logic.
- Potentials storage is a register array in the top module.

Test Plan:
- Reset then idle: rst 2 cycles -> spikes=0, busy=0, done=0, w_rd_en=0; potentials read back 0 via the first frame.
- Single frame latency: all neurons bias=10, weights 0, start at t -> w_rd_en at t+1,t+4,...,t+16 with w_addr 0..5; done at t+19; spikes=0; pot=10 each.
- Integrate to fire: mac_out=+40 per frame for neuron 2 (others 0) -> frames 1-2 spikes=0, frame 3 spikes[2]=1 (sum 120>=100), frame 4 pot restarts from 0 and spikes[2]=0.
- Negative saturation: mac_out=-128 for 20 frames -> potential clamps at -2048 with no wrap; then +127 per frame requires 17 frames to climb to 100 and fire.
- Start while busy / clear: pulse start mid-frame -> ignored, single done; clear_mem+start together in IDLE after pot=90 -> a frame with mac_out=20 gives no spike (pot=20).
- Reset mid-frame: rst asserted in EVAL of neuron 3 -> no done, spikes stays at previous value 0, state IDLE, a subsequent frame behaves as from reset.
